// File: rtl/alu_flag_wb.sv
// alu_flag_wb: writeback and flag stage behind the 20-bit ALU.
// It accepts one ALU result per valid/ready transaction.
// It owns the status register {trap, carry, sign, zero}.
// It resolves jumps and status ops, and it buffers one register-file writeback.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            upstream handshake (in_ready is combinational)
//   in_op, in_result, in_zero,
//   in_carry, in_wr_en,
//   in_wr_addr, in_target        transaction payload
//   wb_valid/wb_ready,
//   wb_addr, wb_data             one-entry writeback buffer to the register file
//   status                       {T, C, S, Z}
//   pc_load, pc_target           single-cycle redirect to fetch
//   trap                         sticky trap bit (status[3])
module alu_flag_wb #(
    parameter int unsigned DW = 20,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [DW-1:0] in_result,
    input  logic          in_zero,
    input  logic          in_carry,
    input  logic          in_wr_en,
    input  logic [AW-1:0] in_wr_addr,
    input  logic [DW-1:0] in_target,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic [3:0]    status,
    output logic          pc_load,
    output logic [DW-1:0] pc_target,
    output logic          trap
);

    localparam logic [3:0] OP_ALU  = 4'd0;
    localparam logic [3:0] OP_JMP  = 4'd2;
    localparam logic [3:0] OP_JZ   = 4'd3;
    localparam logic [3:0] OP_JS   = 4'd4;
    localparam logic [3:0] OP_JZS  = 4'd5;
    localparam logic [3:0] OP_LSR  = 4'd6;
    localparam logic [3:0] OP_XSR  = 4'd7;
    localparam logic [3:0] OP_TRAP = 4'd8;

    logic          accept;
    logic          take;
    logic [3:0]    status_n;
    logic          wb_valid_n;
    logic [AW-1:0] wb_addr_n;
    logic [DW-1:0] wb_data_n;
    logic          pc_load_n;
    logic [DW-1:0] pc_target_n;

    // A stalled writeback entry blocks everything (in-order), and so does a trap.
    assign in_ready = !status[3] && (!wb_valid || wb_ready);
    assign accept   = in_valid && in_ready;
    assign trap     = status[3];

    // Next-state: the jump conditions read the registered (pre-update) flags.
    always_comb begin
        status_n    = status;
        wb_valid_n  = wb_valid;
        wb_addr_n   = wb_addr;
        wb_data_n   = wb_data;
        pc_load_n   = 1'b0;
        pc_target_n = pc_target;
        take        = 1'b0;

        if (wb_valid && wb_ready) begin
            wb_valid_n = 1'b0;
        end

        if (accept) begin
            case (in_op)
                OP_ALU: begin
                    status_n[0] = in_zero;
                    status_n[1] = in_result[DW-1];
                    status_n[2] = in_carry;
                    // An entry that drains this cycle may be replaced directly.
                    if (in_wr_en) begin
                        wb_valid_n = 1'b1;
                        wb_addr_n  = in_wr_addr;
                        wb_data_n  = in_result;
                    end
                end
                OP_JMP:  take = 1'b1;
                OP_JZ:   take = status[0];
                OP_JS:   take = status[1];
                OP_JZS:  take = status[0] | status[1];
                OP_LSR:  status_n[2:0] = in_result[2:0];
                OP_XSR:  status_n[2:0] = status[2:0] ^ in_result[2:0];
                OP_TRAP: status_n[3] = 1'b1;
                default: ;
            endcase
        end

        if (take) begin
            pc_load_n   = 1'b1;
            pc_target_n = in_target;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            status    <= 4'b0;
            wb_valid  <= 1'b0;
            wb_addr   <= AW'(0);
            wb_data   <= DW'(0);
            pc_load   <= 1'b0;
            pc_target <= DW'(0);
        end else begin
            status    <= status_n;
            wb_valid  <= wb_valid_n;
            wb_addr   <= wb_addr_n;
            wb_data   <= wb_data_n;
            pc_load   <= pc_load_n;
            pc_target <= pc_target_n;
        end
    end

endmodule

// File: tb/tb_alu_flag_wb.sv
// Directed testbench for alu_flag_wb.
// Each scenario task drives its vectors and checks the results inline.
module tb_alu_flag_wb;

    localparam int unsigned DW = 20;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [DW-1:0] in_result;
    logic          in_zero;
    logic          in_carry;
    logic          in_wr_en;
    logic [AW-1:0] in_wr_addr;
    logic [DW-1:0] in_target;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [3:0]    status;
    logic          pc_load;
    logic [DW-1:0] pc_target;
    logic          trap;

    int errors = 0;
    int checks = 0;

    alu_flag_wb #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_result(in_result), .in_zero(in_zero), .in_carry(in_carry),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_target(in_target),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .status(status), .pc_load(pc_load), .pc_target(pc_target), .trap(trap)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [DW-1:0] res,
                         input logic z, input logic c, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] tgt);
        in_valid   = 1'b1;
        in_op      = op;
        in_result  = res;
        in_zero    = z;
        in_carry   = c;
        in_wr_en   = we;
        in_wr_addr = addr;
        in_target  = tgt;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_op    = 4'd1;
        in_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_ready = 1'b1; idle();
        in_result = '0; in_zero = 0; in_carry = 0; in_wr_addr = '0; in_target = '0;
        cycle(); cycle();
        rst = 1'b0;
        checks++; if (status !== 4'b0) begin errors++; $display("FAIL reset_status got=%b exp=0000", status); end
        checks++; if (wb_valid !== 1'b0 || wb_addr !== 4'd0 || wb_data !== 20'h0) begin
            errors++; $display("FAIL reset_wb got v=%b a=%h d=%h exp 0/0/0", wb_valid, wb_addr, wb_data); end
        checks++; if (pc_load !== 1'b0 || pc_target !== 20'h0) begin
            errors++; $display("FAIL reset_pc got load=%b tgt=%h exp 0/0", pc_load, pc_target); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_alu_wb();
        drive(4'd0, 20'h80000, 1'b0, 1'b1, 1'b1, 4'd3, 20'h0);
        cycle(); idle();
        checks++; if (status !== 4'b0110) begin errors++; $display("FAIL alu_status got=%b exp=0110", status); end
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd3 || wb_data !== 20'h80000) begin
            errors++; $display("FAIL alu_wb got v=%b a=%h d=%h exp 1/3/80000", wb_valid, wb_addr, wb_data); end
        cycle();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_drain got=%b exp=0", wb_valid); end
    endtask

    task automatic test_jump();
        drive(4'd0, 20'h0, 1'b1, 1'b0, 1'b0, 4'd0, 20'h0);
        cycle();
        checks++; if (status !== 4'b0001 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL jz_setup got st=%b v=%b exp 0001/0", status, wb_valid); end
        drive(4'd3, 20'h0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h00100);
        cycle();
        checks++; if (pc_load !== 1'b1 || pc_target !== 20'h00100) begin
            errors++; $display("FAIL jz_taken got load=%b tgt=%h exp 1/00100", pc_load, pc_target); end
        drive(4'd4, 20'h0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h00200);
        cycle();
        checks++; if (pc_load !== 1'b0 || pc_target !== 20'h00100) begin
            errors++; $display("FAIL js_not_taken got load=%b tgt=%h exp 0/00100", pc_load, pc_target); end
        drive(4'd5, 20'h0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h00300);
        cycle();
        checks++; if (pc_load !== 1'b1 || pc_target !== 20'h00300) begin
            errors++; $display("FAIL jzs_taken got load=%b tgt=%h exp 1/00300", pc_load, pc_target); end
        idle();
        cycle();
        checks++; if (pc_load !== 1'b0 || status !== 4'b0001) begin
            errors++; $display("FAIL jump_pulse got load=%b st=%b exp 0/0001", pc_load, status); end
        // With Z=S=0, only the unconditional jump redirects.
        drive(4'd0, 20'h00001, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0);
        cycle();
        drive(4'd5, 20'h0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h00400);
        cycle();
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL jzs_not_taken got=%b exp=0", pc_load); end
        drive(4'd2, 20'h0, 1'b0, 1'b0, 1'b0, 4'd0, 20'hABCDE);
        cycle(); idle();
        checks++; if (pc_load !== 1'b1 || pc_target !== 20'hABCDE) begin
            errors++; $display("FAIL jmp got load=%b tgt=%h exp 1/abcde", pc_load, pc_target); end
        cycle();
    endtask

    task automatic test_stall();
        wb_ready = 1'b0;
        drive(4'd0, 20'h12345, 1'b0, 1'b0, 1'b1, 4'd5, 20'h0);
        cycle();
        drive(4'd0, 20'h0ABCD, 1'b0, 1'b0, 1'b1, 4'd6, 20'h0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", in_ready); end
        cycle();
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd5 || wb_data !== 20'h12345) begin
            errors++; $display("FAIL stall_hold got v=%b a=%h d=%h exp 1/5/12345", wb_valid, wb_addr, wb_data); end
        wb_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got=%b exp=1", in_ready); end
        cycle(); idle();
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd6 || wb_data !== 20'h0ABCD) begin
            errors++; $display("FAIL replace got v=%b a=%h d=%h exp 1/6/0abcd", wb_valid, wb_addr, wb_data); end
        cycle();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL replace_drain got=%b exp=0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        for (int i = 0; i < 3; i++) begin
            d = DW'(20'h11111 * (i + 1));
            drive(4'd0, d, 1'b0, 1'b0, 1'b1, AW'(8 + i), 20'h0);
            cycle();
            checks++; if (wb_valid !== 1'b1 || wb_addr !== AW'(8 + i) || wb_data !== d) begin
                errors++; $display("FAIL b2b_%0d got v=%b a=%h d=%h exp 1/%h/%h", i, wb_valid, wb_addr, wb_data, AW'(8 + i), d); end
        end
        idle();
        cycle();
    endtask

    task automatic test_status_ops();
        drive(4'd6, 20'h00005, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0);
        cycle();
        checks++; if (status !== 4'b0101) begin errors++; $display("FAIL lsr got=%b exp=0101", status); end
        drive(4'd7, 20'h00003, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0);
        cycle();
        checks++; if (status !== 4'b0110) begin errors++; $display("FAIL xsr got=%b exp=0110", status); end
        drive(4'd6, 20'hFFFFF, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0);
        cycle(); idle();
        checks++; if (status !== 4'b0111 || trap !== 1'b0) begin
            errors++; $display("FAIL lsr_all got st=%b trap=%b exp 0111/0", status, trap); end
    endtask

    task automatic test_nop_ops();
        drive(4'd12, 20'h55555, 1'b0, 1'b0, 1'b1, 4'd9, 20'h00700);
        cycle();
        checks++; if (status !== 4'b0111 || wb_valid !== 1'b0 || pc_load !== 1'b0) begin
            errors++; $display("FAIL op12 got st=%b v=%b load=%b exp 0111/0/0", status, wb_valid, pc_load); end
        drive(4'd1, 20'h00000, 1'b1, 1'b0, 1'b1, 4'd9, 20'h0);
        cycle(); idle();
        checks++; if (status !== 4'b0111 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL nop got st=%b v=%b exp 0111/0", status, wb_valid); end
    endtask

    task automatic test_trap();
        int bad;
        drive(4'd8, 20'h0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0);
        cycle();
        checks++; if (status !== 4'b1111 || trap !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL trap got st=%b trap=%b rdy=%b exp 1111/1/0", status, trap, in_ready); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) drive(4'd0, 20'h00000, 1'b1, 1'b0, 1'b1, 4'd1, 20'h0);
            else            drive(4'd2, 20'h0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h00900);
            cycle();
            if (in_ready !== 1'b0 || pc_load !== 1'b0 || wb_valid !== 1'b0 || status !== 4'b1111) bad++;
        end
        idle();
        checks++; if (bad !== 0) begin errors++; $display("FAIL trap_hold got bad_cycles=%0d exp=0", bad); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++; if (status !== 4'b0 || trap !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL trap_reset got st=%b trap=%b rdy=%b exp 0000/0/1", status, trap, in_ready); end
    endtask

    task automatic test_reset_drops_wb();
        wb_ready = 1'b0;
        drive(4'd0, 20'h00042, 1'b0, 1'b0, 1'b1, 4'd7, 20'h0);
        cycle(); idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; wb_ready = 1'b1;
        checks++; if (wb_valid !== 1'b0 || wb_addr !== 4'd0 || wb_data !== 20'h0) begin
            errors++; $display("FAIL reset_drop got v=%b a=%h d=%h exp 0/0/0", wb_valid, wb_addr, wb_data); end
    endtask

    initial begin
        test_reset();
        test_alu_wb();
        test_jump();
        test_stall();
        test_back_to_back();
        test_status_ops();
        test_nop_ops();
        test_trap();
        test_reset_drops_wb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_flag_wb.md
Name: alu_flag_wb

Overview:
Writeback and flag stage sitting directly downstream of the 20-bit ALU operation circuits. It accepts one ALU result per transaction over a valid/ready handshake. It owns the architectural status register (zero, sign, carry, trap), resolves the program-flow operations (jumps, status load/XOR, trap), and drives register-file writeback through a one-entry output buffer. Control-flow redirects go to the fetch stage as a single-cycle PC-load pulse.

Parameters:
DW, 20, datapath width (ALU result, jump target, writeback data)
AW, 4, register-file address width

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream ALU transaction valid
in_ready  out  1  stage can accept a transaction this cycle
in_op  in  4  operation class (encoding below)
in_result  in  DW  ALU result
in_zero  in  1  ALU zero flag
in_carry  in  1  ALU carry flag
in_wr_en  in  1  result is to be written to the register file (op 0 only)
in_wr_addr  in  AW  destination register
in_target  in  DW  jump target address
wb_valid  out  1  writeback entry valid
wb_ready  in  1  register file accepts the entry
wb_addr  out  AW  writeback destination
wb_data  out  DW  writeback data
status  out  4  {trap, carry, sign, zero} = bits [3:0] as T,C,S,Z
pc_load  out  1  one-cycle redirect strobe
pc_target  out  DW  redirect address, valid while pc_load=1
trap  out  1  equals status[3]

Behaviour:
- Reset (rst=1 at clock edge) clears every output and register:
  - status=0, wb_valid=0, wb_addr=0, wb_data=0, pc_load=0, pc_target=0.
  - Reset mid-transaction drops the buffered writeback entry.
- in_ready = !trap && (!wb_valid || wb_ready). This is combinational.
- A transaction is accepted on a cycle where in_valid && in_ready. Every effect of an accepted transaction is visible on the next cycle (latency 1).
- Op encoding:
  - 0 ALU: Z<=in_zero, S<=in_result[DW-1], C<=in_carry. If in_wr_en=1, load the wb entry (wb_valid<=1, addr, data=in_result).
  - 1 NOP: no state change.
  - 2 JMP: pc_load<=1, pc_target<=in_target.
  - 3 JZ: redirect only if Z=1.
  - 4 JS: redirect only if S=1.
  - 5 JZS: redirect only if Z|S, i.e. result <= 0 signed.
  - 6 LSR: status[2:0] <= in_result[2:0].
  - 7 XSR: status[2:0] <= status[2:0] ^ in_result[2:0].
  - 8 TRAP: status[3] <= 1.
  - 9-15: treated as NOP.
- Writes to the trap bit:
  - in_wr_en is ignored for every op except 0.
  - LSR and XSR never modify the trap bit.
- Jump conditions sample the registered status (pre-update). An op 0 accepted in cycle N is seen by a jump accepted in cycle N+1 (no bypass needed because of the 1-cycle register). Jumps never modify flags.
- pc_load is high for exactly one cycle per taken jump. A not-taken jump produces pc_load=0 and pc_target unchanged.
- Writeback buffer:
  - The entry is cleared when wb_valid && wb_ready, unless a new op 0 with wr_en is accepted in the same cycle. In that case the entry is replaced (back-to-back throughput of 1/cycle).
  - wb_addr and wb_data are held stable while wb_valid && !wb_ready.
  - Non-writing ops accepted while the entry is stalled are not possible, because in_ready=0 whenever wb_valid && !wb_ready (in-order stall).
- Trap:
  - The trap bit is sticky; only rst clears it.
  - While trapped, in_ready=0 and no new transactions are accepted.
  - A pending wb entry still drains normally after trap.
- in_valid with in_ready=0: the stage takes no action. Upstream must hold its inputs stable until acceptance.

Test Plan:
- Reset then op0 result=0x80000, carry=1, wr_en=1, addr=3 -> next cycle status=4'b0110, wb_valid=1, wb_addr=3, wb_data=0x80000.
- op0 result=0 zero=1, then JZ target=0x00100 in the following cycle -> pc_load=1 for one cycle, pc_target=0x00100. Then JS target=0x00200 -> pc_load stays 0.
- wb_ready=0 with an entry pending, in_valid=1 -> in_ready=0 and the entry is held. Raise wb_ready -> entry drains and the next op0 is accepted the same cycle (buffer replaced, no bubble).
- LSR result=0x00005 -> status=4'b0101. Then XSR result=0x00003 -> status=4'b0110. Then LSR result=0xFFFFF -> status=4'b0111 (trap untouched).
- TRAP op -> trap=1, in_ready=0 thereafter, in_valid ignored for 10 cycles. Then rst=1 for one cycle -> status=0, in_ready=1.
- Op 12 with wr_en=1 -> no writeback, no flag change; behaves as NOP.
